// File: rtl/bram_dp.sv
// Dual-port block RAM: port A read/write with byte enables, port B read-only,
// optional output register and a clear engine that zeroes the array one word per cycle.
module bram_dp #(
    parameter int RAM_WIDTH      = 16,
    parameter int RAM_ADDR_BITS  = 8,
    parameter int BYTE_WIDTH     = 8,
    parameter int OUTPUT_REG     = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                clear,
    output logic                                busy,
    input  logic                                a_enable,
    input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]     a_write_enable,
    input  logic [RAM_ADDR_BITS-1:0]            a_address,
    input  logic [RAM_WIDTH-1:0]                a_input_data,
    output logic [RAM_WIDTH-1:0]                a_output_data,
    output logic                                a_valid,
    input  logic                                b_enable,
    input  logic [RAM_ADDR_BITS-1:0]            b_address,
    output logic [RAM_WIDTH-1:0]                b_output_data,
    output logic                                b_valid
);

    // state | meaning
    // IDLE  | ports A/B own the array
    // CLEAR | engine writes zero to clr_addr_q each cycle; port accesses dropped

    localparam int NB    = RAM_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** RAM_ADDR_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] clr_addr_q, clr_addr_d;

    logic [RAM_WIDTH-1:0]     mem [DEPTH];

    logic                     a_acc, b_acc;
    logic [RAM_WIDTH-1:0]     a_old, a_merged, a_rd, b_old;

    logic [RAM_WIDTH-1:0]     a_data_q, b_data_q;
    logic                     a_vld_q, b_vld_q;

    assign busy = (state_q == CLEAR);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                clr_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign a_acc = a_enable && !busy;
    assign b_acc = b_enable && !busy;

    assign a_old = mem[a_address];
    assign b_old = mem[b_address];

    always_comb begin
        a_merged = a_old;
        for (int i = 0; i < NB; i++) begin
            if (a_write_enable[i]) begin
                a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = a_input_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign a_rd = (RDW_MODE != 0) ? a_merged : a_old;

    // Array has no reset; writes are simply suppressed while reset is held.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (busy) begin
                mem[clr_addr_q] <= '0;
            end else if (a_acc && (|a_write_enable)) begin
                mem[a_address] <= a_merged;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_data_q <= '0;
            a_vld_q  <= 1'b0;
            b_data_q <= '0;
            b_vld_q  <= 1'b0;
        end else begin
            a_vld_q <= a_acc;
            b_vld_q <= b_acc;
            if (a_acc) begin
                a_data_q <= a_rd;
            end
            if (b_acc) begin
                b_data_q <= b_old;
            end
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic [RAM_WIDTH-1:0] a_data2_q, b_data2_q;
        logic                 a_vld2_q, b_vld2_q;

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                a_data2_q <= '0;
                a_vld2_q  <= 1'b0;
                b_data2_q <= '0;
                b_vld2_q  <= 1'b0;
            end else begin
                a_vld2_q <= a_vld_q;
                b_vld2_q <= b_vld_q;
                if (a_vld_q) begin
                    a_data2_q <= a_data_q;
                end
                if (b_vld_q) begin
                    b_data2_q <= b_data_q;
                end
            end
        end

        assign a_output_data = a_data2_q;
        assign a_valid       = a_vld2_q;
        assign b_output_data = b_data2_q;
        assign b_valid       = b_vld2_q;
    end else begin : g_noreg
        assign a_output_data = a_data_q;
        assign a_valid       = a_vld_q;
        assign b_output_data = b_data_q;
        assign b_valid       = b_vld_q;
    end

endmodule

// File: tb/tb_bram_dp.sv
// Bench for bram_dp: two instances (latency 1 / READ_FIRST and latency 2 / WRITE_FIRST)
// share stimulus; expected reads are queued with a due cycle and checked by a monitor.
module tb_bram_dp;

    typedef struct packed {
        logic [15:0] d;
        logic [31:0] due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n, clear;
    logic        a_en, b_en;
    logic [1:0]  a_we;
    logic [3:0]  a_addr, b_addr;
    logic [15:0] a_din;

    logic        busy0, busy1, a_vld0, a_vld1, b_vld0, b_vld1;
    logic [15:0] a_out0, a_out1, b_out0, b_out1;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb [4][$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    bram_dp #(.RAM_WIDTH(16), .RAM_ADDR_BITS(4), .BYTE_WIDTH(8), .OUTPUT_REG(0),
              .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy0),
        .a_enable(a_en), .a_write_enable(a_we), .a_address(a_addr), .a_input_data(a_din),
        .a_output_data(a_out0), .a_valid(a_vld0),
        .b_enable(b_en), .b_address(b_addr), .b_output_data(b_out0), .b_valid(b_vld0));

    bram_dp #(.RAM_WIDTH(16), .RAM_ADDR_BITS(4), .BYTE_WIDTH(8), .OUTPUT_REG(1),
              .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy1),
        .a_enable(a_en), .a_write_enable(a_we), .a_address(a_addr), .a_input_data(a_din),
        .a_output_data(a_out1), .a_valid(a_vld1),
        .b_enable(b_en), .b_address(b_addr), .b_output_data(b_out1), .b_valid(b_vld1));

    function automatic string port_name(input int k);
        case (k)
            0: return "u0.portA";
            1: return "u0.portB";
            2: return "u1.portA";
            default: return "u1.portB";
        endcase
    endfunction

    // Monitor: every valid pulse must match the head of its queue in data and cycle.
    always @(negedge clock) begin
        logic [3:0]  v;
        logic [15:0] d [4];
        exp_t        e;
        v    = {b_vld1, a_vld1, b_vld0, a_vld0};
        d[0] = a_out0;
        d[1] = b_out0;
        d[2] = a_out1;
        d[3] = b_out1;
        for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
                n_cmp++;
                if (sb[k].size() == 0) begin
                    n_err++;
                    $display("FAIL %s unexpected valid: got data %h at cycle %0d, required no valid",
                             port_name(k), d[k], cyc);
                end else begin
                    e = sb[k].pop_front();
                    if (d[k] !== e.d || cyc !== int'(e.due)) begin
                        n_err++;
                        $display("FAIL %s read: got %h at cycle %0d, required %h at cycle %0d",
                                 port_name(k), d[k], cyc, e.d, e.due);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        a_en  = 1'b0;
        b_en  = 1'b0;
        a_we  = 2'b00;
        clear = 1'b0;
    endtask

    task automatic push(input int k, input logic [15:0] d, input int lat);
        exp_t e;
        e.d   = d;
        e.due = 32'(cyc + lat);
        sb[k].push_back(e);
    endtask

    // Port A access: exp0 is the READ_FIRST result, exp1 the WRITE_FIRST result.
    task automatic acc_a(input logic [3:0] addr, input logic [1:0] we, input logic [15:0] din,
                         input logic [15:0] exp0, input logic [15:0] exp1);
        a_en   = 1'b1;
        a_we   = we;
        a_addr = addr;
        a_din  = din;
        push(0, exp0, 1);
        push(2, exp1, 2);
    endtask

    task automatic acc_b(input logic [3:0] addr, input logic [15:0] exp);
        b_en   = 1'b1;
        b_addr = addr;
        push(1, exp, 1);
        push(3, exp, 2);
    endtask

    // Counts busy cycles; with poke set, issues ignored accesses and clear pulses
    // mid-sequence (n==5) and in the exit cycle (n==16).
    task automatic busy_run(input bit poke, output int n0, output int n1);
        int n;
        n  = 0;
        n0 = 0;
        n1 = 0;
        while ((busy0 || busy1) && n < 64) begin
            n++;
            if (busy0) n0++;
            if (busy1) n1++;
            if (poke) begin
                clear  = (n == 5 || n == 16);
                a_en   = 1'b1;
                a_we   = 2'b11;
                a_addr = n[3:0];
                a_din  = 16'hDEAD;
                b_en   = 1'b1;
                b_addr = n[3:0];
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        reset_n = 1'b0;
        clear   = 1'b0;
        a_en    = 1'b0;
        b_en    = 1'b0;
        a_we    = 2'b00;
        a_addr  = '0;
        b_addr  = '0;
        a_din   = '0;
        repeat (3) step();

        chk("reset u0.a_output_data", 32'(a_out0), 32'h0);
        chk("reset u0.b_output_data", 32'(b_out0), 32'h0);
        chk("reset u1.a_output_data", 32'(a_out1), 32'h0);
        chk("reset u1.b_output_data", 32'(b_out1), 32'h0);
        chk("reset valids", 32'({a_vld0, b_vld0, a_vld1, b_vld1}), 32'h0);
        chk("reset u0.busy", 32'(busy0), 32'h1);
        chk("reset u1.busy", 32'(busy1), 32'h1);

        reset_n = 1'b1;
        busy_run(1'b0, n0, n1);
        chk("power-up clear length u0", 32'(n0), 32'd16);
        chk("power-up clear length u1", 32'(n1), 32'd16);

        for (int i = 0; i < 16; i++) begin
            acc_b(4'(i), 16'h0000);
            step();
        end

        acc_a(4'd3, 2'b11, 16'hA1B2, 16'h0000, 16'hA1B2);
        step();
        acc_a(4'd3, 2'b01, 16'hFFCC, 16'hA1B2, 16'hA1CC);
        step();
        acc_a(4'd3, 2'b00, 16'h0000, 16'hA1CC, 16'hA1CC);
        step();

        acc_a(4'd5, 2'b11, 16'h1111, 16'h0000, 16'h1111);
        step();
        acc_a(4'd5, 2'b11, 16'h2222, 16'h1111, 16'h2222);
        acc_b(4'd5, 16'h1111);
        step();
        acc_a(4'd5, 2'b00, 16'h0000, 16'h2222, 16'h2222);
        acc_b(4'd5, 16'h2222);
        step();
        repeat (3) step();
        chk("hold u0.a_output_data", 32'(a_out0), 32'h2222);
        chk("hold u1.a_output_data", 32'(a_out1), 32'h2222);

        acc_a(4'd0, 2'b11, 16'h1000, 16'h0000, 16'h1000);
        step();
        acc_a(4'd1, 2'b11, 16'h1001, 16'h0000, 16'h1001);
        step();
        acc_a(4'd2, 2'b10, 16'h1002, 16'h0000, 16'h1000);
        step();
        acc_a(4'd0, 2'b00, 16'h0, 16'h1000, 16'h1000);
        step();
        acc_a(4'd1, 2'b00, 16'h0, 16'h1001, 16'h1001);
        step();
        acc_a(4'd2, 2'b00, 16'h0, 16'h1000, 16'h1000);
        step();
        acc_a(4'd3, 2'b00, 16'h0, 16'hA1CC, 16'hA1CC);
        step();
        repeat (3) step();

        clear = 1'b1;
        acc_b(4'd3, 16'hA1CC);
        step();
        busy_run(1'b1, n0, n1);
        chk("clear length u0", 32'(n0), 32'd16);
        chk("clear length u1", 32'(n1), 32'd16);
        step();
        chk("clear at exit ignored u0", 32'(busy0), 32'h0);
        chk("clear at exit ignored u1", 32'(busy1), 32'h0);
        for (int i = 0; i < 16; i++) begin
            acc_a(4'(i), 2'b00, 16'h0, 16'h0000, 16'h0000);
            step();
        end
        repeat (3) step();

        acc_a(4'd9, 2'b11, 16'h5A5A, 16'h0000, 16'h5A5A);
        step();
        clear = 1'b1;
        step();
        repeat (6) step();
        chk("mid-clear busy u0", 32'(busy0), 32'h1);
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        busy_run(1'b0, n0, n1);
        chk("restart after reset u0", 32'(n0), 32'd16);
        chk("restart after reset u1", 32'(n1), 32'd16);
        acc_b(4'd9, 16'h0000);
        step();

        a_en   = 1'b1;
        a_we   = 2'b00;
        a_addr = 4'd9;
        push(0, 16'h0000, 1);
        step();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        busy_run(1'b0, n0, n1);
        chk("in-flight reset clear u1", 32'(n1), 32'd16);
        repeat (4) step();

        for (int k = 0; k < 4; k++) begin
            chk({port_name(k), " pending reads"}, 32'(sb[k].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
